// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch bus between the fetch stage and instruction memory.
//   imemReq   : fetch request (fetch stage -> memory)
//   imemAddr  : fetch address (fetch stage -> memory)
//   imemData  : instruction word, meaningful when imemValid=1 (memory -> fetch stage)
//   imemValid : imemData belongs to the current imemAddr (memory -> fetch stage)
interface fetch_stage_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic        imemValid;

  modport master (output imemReq, output imemAddr, input imemData, input imemValid);
  modport slave  (input imemReq, input imemAddr, output imemData, output imemValid);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests and
// loads the IF/ID pipeline register. Handles ID redirects, hazard stalls and a
// variable-latency memory.
//   Clock, reset      : clock (rising edge), asynchronous active-high reset
//   stall             : hold PC and IF/ID this cycle
//   pcSrc             : 00/11 sequential, 01 branch, 10 jump
//   branchAddress     : branch target from ID
//   jumpAddress       : jump target from ID
//   imem              : instruction-memory bus (request side)
//   instruction_1     : IF/ID instruction
//   pcPlus4_1         : IF/ID PC+4 of that instruction
//   ifIdValid         : IF/ID holds a real instruction
//   fetchBusy         : waiting on memory
//   fetchCount        : instructions delivered to IF/ID
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP      = 32'h00000000
) (
  input  logic                Clock,
  input  logic                reset,
  input  logic                stall,
  input  logic [1:0]          pcSrc,
  input  logic [31:0]         branchAddress,
  input  logic [31:0]         jumpAddress,
  fetch_stage_if.master       imem,
  output logic [31:0]         instruction_1,
  output logic [31:0]         pcPlus4_1,
  output logic                ifIdValid,
  output logic                fetchBusy,
  output logic [31:0]         fetchCount
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_WAIT} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   pc_plus4_q, pc_plus4_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [XLEN-1:0]   count_q, count_d;
  logic              redirect;
  logic [XLEN-1:0]   target;

  assign redirect = (pcSrc == 2'b01) || (pcSrc == 2'b10);
  // Targets are word-aligned; low two bits are discarded.
  assign target   = ((pcSrc == 2'b01) ? branchAddress : jumpAddress) & ~XLEN'(3);

  // State and pipeline registers.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
    end
  end

  // Next-state: priority redirect > stall > memory response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN, S_WAIT: begin
        if (redirect)            state_d = S_RUN;
        else if (stall)          state_d = state_q;
        else if (imem.imemValid) state_d = S_RUN;
        else                     state_d = S_WAIT;
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Outputs and datapath next values.
  always_comb begin
    imem.imemReq  = (state_q != S_BOOT);
    imem.imemAddr = pc_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc_plus4_d    = pc_plus4_q;
    valid_d       = valid_q;
    count_d       = count_q;
    busy_d        = (state_d == S_WAIT);
    if (state_q != S_BOOT) begin
      if (redirect) begin
        // A response arriving alongside a redirect belongs to the wrong path.
        pc_d       = target;
        instr_d    = NOP;
        pc_plus4_d = '0;
        valid_d    = 1'b0;
      end else if (!stall) begin
        if (imem.imemValid) begin
          pc_d       = pc_q + XLEN'(4);
          instr_d    = imem.imemData;
          pc_plus4_d = pc_q + XLEN'(4);
          valid_d    = 1'b1;
          count_d    = count_q + XLEN'(1);
        end else begin
          instr_d    = NOP;
          pc_plus4_d = '0;
          valid_d    = 1'b0;
        end
      end
    end
  end

  assign instruction_1 = instr_q;
  assign pcPlus4_1     = pc_plus4_q;
  assign ifIdValid     = valid_q;
  assign fetchBusy     = busy_q;
  assign fetchCount    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic, all
// compared against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

  logic        Clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  pcSrc = 2'b00;
  logic [31:0] branchAddress = '0;
  logic [31:0] jumpAddress = '0;
  logic [31:0] instruction_1, pcPlus4_1, fetchCount;
  logic        ifIdValid, fetchBusy;

  fetch_stage_if imem_bus ();

  fetch_stage dut (
    .Clock         (Clock),
    .reset         (reset),
    .stall         (stall),
    .pcSrc         (pcSrc),
    .branchAddress (branchAddress),
    .jumpAddress   (jumpAddress),
    .imem          (imem_bus.master),
    .instruction_1 (instruction_1),
    .pcPlus4_1     (pcPlus4_1),
    .ifIdValid     (ifIdValid),
    .fetchBusy     (fetchBusy),
    .fetchCount    (fetchCount)
  );

  always #5 Clock = ~Clock;

  int vectors = 0;
  int miscompares = 0;
  bit mem_const = 1'b1;

  // Reference model: fetch-stage behaviour expressed as architectural values.
  bit          m_boot;
  bit          m_busy;
  logic [31:0] m_pc, m_instr, m_pp4, m_cnt;
  bit          m_v;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_const) return 32'h20080005;
    return {a[15:0], ~a[15:0]} ^ 32'h3C01_8000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_boot = 1'b1; m_busy = 1'b0; m_pc = 32'h0;
    m_instr = 32'h0; m_pp4 = 32'h0; m_v = 1'b0; m_cnt = 32'h0;
  endtask

  // Apply one cycle of inputs, check request side before the edge and the
  // registered outputs after it.
  task automatic cyc(input bit st, input logic [1:0] src, input logic [31:0] br,
                     input logic [31:0] jp, input bit vld);
    logic [31:0] data;
    data = mem_word(m_pc);
    stall = st; pcSrc = src; branchAddress = br; jumpAddress = jp;
    imem_bus.imemValid = vld; imem_bus.imemData = data;
    #1;
    check("imemReq", 32'(imem_bus.imemReq), 32'(!m_boot));
    check("imemAddr", imem_bus.imemAddr, m_pc);
    @(posedge Clock);
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (src == 2'b01 || src == 2'b10) begin
      m_pc = ((src == 2'b01) ? br : jp) & 32'hFFFF_FFFC;
      m_instr = 32'h0; m_pp4 = 32'h0; m_v = 1'b0; m_busy = 1'b0;
    end else if (!st) begin
      if (vld) begin
        m_instr = data; m_pp4 = m_pc + 32'd4; m_v = 1'b1;
        m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1; m_busy = 1'b0;
      end else begin
        m_instr = 32'h0; m_pp4 = 32'h0; m_v = 1'b0; m_busy = 1'b1;
      end
    end
    #1;
    check("instruction_1", instruction_1, m_instr);
    check("pcPlus4_1", pcPlus4_1, m_pp4);
    check("ifIdValid", 32'(ifIdValid), 32'(m_v));
    check("fetchBusy", 32'(fetchBusy), 32'(m_busy));
    check("fetchCount", fetchCount, m_cnt);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"}, 32'(imem_bus.imemReq), 32'h0);
    check({tag, "_addr"}, imem_bus.imemAddr, 32'h0);
    check({tag, "_instr"}, instruction_1, 32'h0);
    check({tag, "_pp4"}, pcPlus4_1, 32'h0);
    check({tag, "_valid"}, 32'(ifIdValid), 32'h0);
    check({tag, "_busy"}, 32'(fetchBusy), 32'h0);
    check({tag, "_cnt"}, fetchCount, 32'h0);
  endtask

  initial begin
    imem_bus.imemValid = 1'b0;
    imem_bus.imemData  = '0;
    m_reset();
    #2;
    check_reset_values("rst");
    @(negedge Clock); @(negedge Clock);
    reset = 1'b0;

    // Zero-wait memory, constant instruction word.
    cyc(0, 2'b00, 0, 0, 1);
    check("boot_req_after", 32'(imem_bus.imemReq), 32'h1);
    for (int i = 0; i < 3; i++) begin
      check("t1_addr", imem_bus.imemAddr, 32'(i * 4));
      cyc(0, 2'b00, 0, 0, 1);
      check("t1_pp4", pcPlus4_1, 32'(i * 4 + 4));
      check("t1_instr", instruction_1, 32'h20080005);
    end
    check("t1_cnt", fetchCount, 32'd3);

    // Two wait cycles at address 0.
    mem_const = 1'b0;
    cyc(0, 2'b10, 0, 32'h0, 1);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 2'b00, 0, 0, 0);
      check("t2_busy", 32'(fetchBusy), 32'h1);
      check("t2_addr", imem_bus.imemAddr, 32'h0);
      check("t2_valid", 32'(ifIdValid), 32'h0);
    end
    cyc(0, 2'b00, 0, 0, 1);
    check("t2_instr", instruction_1, 32'h3C01_8000 ^ 32'h0000_FFFF);
    check("t2_pp4", pcPlus4_1, 32'h4);
    check("t2_busy_clr", 32'(fetchBusy), 32'h0);

    // Stall at pc=8 while memory responds.
    cyc(0, 2'b00, 0, 0, 1);
    check("t3_pc8", imem_bus.imemAddr, 32'h8);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 2'b00, 0, 0, 1);
      check("t3_hold_pc", imem_bus.imemAddr, 32'h8);
      check("t3_hold_pp4", pcPlus4_1, 32'h8);
      check("t3_hold_cnt", fetchCount, 32'd5);
    end
    cyc(0, 2'b00, 0, 0, 1);
    check("t3_pp4", pcPlus4_1, 32'hC);

    // Branch while memory responds.
    cyc(0, 2'b01, 32'h40, 32'h0, 1);
    check("t4_pc", imem_bus.imemAddr, 32'h40);
    check("t4_valid", 32'(ifIdValid), 32'h0);
    check("t4_cnt", fetchCount, 32'd6);
    cyc(0, 2'b00, 0, 0, 1);
    check("t4_pp4", pcPlus4_1, 32'h44);

    // Jump together with stall: redirect wins and target is aligned.
    cyc(1, 2'b10, 32'h0, 32'h103, 1);
    check("t5_pc", imem_bus.imemAddr, 32'h100);

    // Asynchronous reset in the middle of a wait.
    cyc(0, 2'b10, 0, 32'hC, 0);
    cyc(0, 2'b00, 0, 0, 0);
    check("t6_wait", 32'(fetchBusy), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    m_reset();
    check_reset_values("t6_rst");
    @(negedge Clock);
    reset = 1'b0;
    cyc(0, 2'b00, 0, 0, 1);
    check("t6_boot_addr", imem_bus.imemAddr, 32'h0);

    // PC wrap at the top of the address space.
    cyc(0, 2'b10, 0, 32'hFFFF_FFFF, 1);
    check("t7_pc", imem_bus.imemAddr, 32'hFFFF_FFFC);
    cyc(0, 2'b00, 0, 0, 1);
    check("t7_pp4", pcPlus4_1, 32'h0);
    check("t7_wrap", imem_bus.imemAddr, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] src;
      src = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      cyc(bit'($urandom_range(0, 5) == 0), src, $urandom, $urandom,
          bit'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the Antares 5-stage MIPS pipeline: owns the PC, drives the instruction-memory request, and loads the IF/ID pipeline register consumed by the decode stage.
- Applies redirects (branch/jump resolved in ID) and load-use stalls from the hazard unit.
- Tolerates a variable-latency instruction memory through a valid handshake.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP, 32'h00000000, instruction word inserted as a bubble (sll $0,$0,0).

Ports:
- Clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID this cycle.
- pcSrc  in  2  ID redirect select: 00 sequential, 01 branch, 10 jump, 11 treated as 00.
- branchAddress  in  32  branch target from ID.
- jumpAddress  in  32  jump target from ID.
- imemReq  out  1  instruction fetch request.
- imemAddr  out  32  fetch address (= pc).
- imemData  in  32  instruction word; meaningful only when imemValid=1.
- imemValid  in  1  imemData corresponds to the current imemAddr; may rise in the same cycle as the request (zero-wait) or later.
- instruction_1  out  32  IF/ID instruction.
- pcPlus4_1  out  32  IF/ID PC+4 of that instruction.
- ifIdValid  out  1  IF/ID holds a real instruction.
- fetchBusy  out  1  1 while waiting on memory (state WAIT).
- fetchCount  out  32  count of instructions delivered to IF/ID.

Behaviour:
- Reset (asynchronous, any time, including mid-wait):
  - pc=RESET_PC, instruction_1=NOP, pcPlus4_1=0, ifIdValid=0, fetchCount=0, state=BOOT.
  - imemReq=0, fetchBusy=0.
- FSM states BOOT, RUN, WAIT:
  - BOOT: imemReq=0 for exactly one cycle after reset deasserts, then RUN unconditionally. IF/ID holds bubble.
  - RUN and WAIT: imemReq=1 and imemAddr=pc, held stable until accepted or redirected. fetchBusy=1 only in WAIT.
- Per-cycle priority in RUN/WAIT is reset > redirect > stall > normal.
- Redirect (pcSrc = 01 or 10):
  - pc <= target with bits[1:0] forced to 00; IF/ID <= {NOP, 0, valid 0}.
  - Any imemValid in that cycle is ignored; fetchCount unchanged; next state RUN.
- Stall (no redirect):
  - pc, IF/ID and fetchCount hold; state holds.
  - imemValid that cycle is ignored, so the same address is re-fetched after the stall.
- Normal, imemValid=1:
  - IF/ID <= {imemData, pc+4, valid 1}; pc <= pc+4; fetchCount+1; next state RUN.
- Normal, imemValid=0:
  - IF/ID <= bubble {NOP, 0, valid 0}; pc holds; next state WAIT.
- Arithmetic:
  - pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 0); fetchCount wraps modulo 2^32.
- Latency:
  - With a zero-wait memory, an instruction at address A is on IF/ID one cycle after pc=A; sustained throughput is one instruction per cycle.
- Outputs are registered, except imemReq and imemAddr, which decode directly from state and pc.

Test Plan:
- Reset, then zero-wait memory returning 32'h20080005 for every address -> BOOT cycle with imemReq=0; then imemAddr 0,4,8; IF/ID shows pcPlus4_1=4,8,12 with ifIdValid=1; fetchCount=3 after 3 fetches.
- Memory with 2 wait cycles at address 0 -> fetchBusy=1 for 2 cycles with imemAddr=0 held and ifIdValid=0; then instruction_1=mem[0] and pcPlus4_1=4.
- stall=1 for 2 cycles at pc=8 while imemValid=1 -> pc stays 8, IF/ID unchanged, fetchCount unchanged; after release, address 8 is fetched and delivered.
- pcSrc=01 with branchAddress=32'h40 while imemValid=1 -> next pc=32'h40, ifIdValid=0, fetchCount unchanged; next instruction has pcPlus4_1=32'h44.
- pcSrc=10 with jumpAddress=32'h103 and stall=1 in the same cycle -> redirect wins; pc=32'h100.
- Assert reset mid-WAIT at pc=32'hC -> outputs return to reset values immediately; pc=0, BOOT cycle repeats.
- pc forced to 32'hFFFFFFFC by a jump, then a normal fetch -> pcPlus4_1=0 and pc=0.
